// File: rtl/riscv_muldiv_pkg.sv
// Shared types and operation-decode helpers for the iterative RV32M/RV64M multiply-divide unit.
package riscv_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_rs1(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_rs2(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative multiply/divide: radix-2 shift-add multiply and restoring divide, one bit per cycle,
// with single-cycle completion for divide-by-zero and signed overflow.
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              kill,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  result_tag
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  muldiv_state_e state_q, state_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  muldiv_op_e          op_q, op_d;
  logic                neg_q, neg_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [2*DATA_W:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TAG_W-1:0]    pend_tag_q, pend_tag_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [TAG_W-1:0]    result_tag_q, result_tag_d;

  muldiv_op_e          op_in_s;
  logic                sign1_s, sign2_s, neg_in_s;
  logic [DATA_W-1:0]   mag1_s, mag2_s;
  logic                div_zero_s, ovf_s, special_s, accept_s;
  logic [DATA_W-1:0]   special_res_s;
  logic [DATA_W:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic                div_ge_s;
  logic [2*DATA_W:0]   mul_next_s, div_next_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   quot_s, rem_s, fix_res_s;

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign result_tag = result_tag_q;

  // Operand decode at accept: magnitudes, result sign and the divide special cases.
  always_comb begin
    op_in_s    = muldiv_op_e'(op);
    sign1_s    = is_signed_rs1(op_in_s) & rs1_data[DATA_W-1];
    sign2_s    = is_signed_rs2(op_in_s) & rs2_data[DATA_W-1];
    mag1_s     = sign1_s ? ('0 - rs1_data) : rs1_data;
    mag2_s     = sign2_s ? ('0 - rs2_data) : rs2_data;
    neg_in_s   = (op_in_s inside {OP_REM, OP_REMU}) ? sign1_s : (sign1_s ^ sign2_s);
    div_zero_s = is_div(op_in_s) && (rs2_data == '0);
    ovf_s      = (op_in_s inside {OP_DIV, OP_REM}) && (rs1_data == MOST_NEG) && (rs2_data == '1);
    special_s  = div_zero_s | ovf_s;
    accept_s   = start & ~kill & ((state_q == IDLE) | (state_q == DONE));
    if (div_zero_s) begin
      special_res_s = op[1] ? rs1_data : '1;
    end else begin
      special_res_s = op[1] ? '0 : rs1_data;
    end
  end

  // One iteration step; acc holds {carry, hi, lo} = product or {remainder, quotient}.
  always_comb begin
    mul_sum_s   = acc_q[2*DATA_W:DATA_W] + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next_s  = {1'b0, mul_sum_s, acc_q[DATA_W-1:1]};
    div_shift_s = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_ge_s    = div_shift_s >= {1'b0, opb_q};
    div_diff_s  = div_shift_s - {1'b0, opb_q};
    div_next_s  = div_ge_s ? {div_diff_s, acc_q[DATA_W-2:0], 1'b1}
                           : {div_shift_s, acc_q[DATA_W-2:0], 1'b0};
  end

  // Sign correction and result selection applied in FIX.
  always_comb begin
    prod_s = neg_q ? ('0 - acc_q[2*DATA_W-1:0]) : acc_q[2*DATA_W-1:0];
    quot_s = neg_q ? ('0 - acc_q[DATA_W-1:0]) : acc_q[DATA_W-1:0];
    rem_s  = neg_q ? ('0 - acc_q[2*DATA_W-1:DATA_W]) : acc_q[2*DATA_W-1:DATA_W];
    case (op_q)
      OP_MUL:                       fix_res_s = prod_s[DATA_W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_s[2*DATA_W-1:DATA_W];
      OP_DIV, OP_DIVU:              fix_res_s = quot_s;
      OP_REM, OP_REMU:              fix_res_s = rem_s;
      default:                      fix_res_s = '0;
    endcase
  end

  // Datapath next-state: load on accept, iterate in CALC, publish in FIX.
  always_comb begin
    op_d         = op_q;
    neg_d        = neg_q;
    opb_d        = opb_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    pend_tag_d   = pend_tag_q;
    result_d     = result_q;
    result_tag_d = result_tag_q;
    if (accept_s) begin
      op_d       = op_in_s;
      neg_d      = neg_in_s;
      opb_d      = mag2_s;
      acc_d      = {{(DATA_W+1){1'b0}}, mag1_s};
      cnt_d      = CNT_LAST;
      pend_tag_d = rd_tag;
      if (special_s) begin
        result_d     = special_res_s;
        result_tag_d = rd_tag;
      end else begin
        result_d     = result_q;
      end
    end else if ((state_q == CALC) && !kill) begin
      acc_d = is_div(op_q) ? div_next_s : mul_next_s;
      cnt_d = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : cnt_q;
    end else if ((state_q == FIX) && !kill) begin
      result_d     = fix_res_s;
      result_tag_d = pend_tag_q;
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q         <= OP_MUL;
      neg_q        <= 1'b0;
      opb_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      pend_tag_q   <= '0;
      result_q     <= '0;
      result_tag_q <= '0;
    end else begin
      op_q         <= op_d;
      neg_q        <= neg_d;
      opb_q        <= opb_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      pend_tag_q   <= pend_tag_d;
      result_q     <= result_d;
      result_tag_q <= result_tag_d;
    end
  end

  // FSM next state; kill always returns to IDLE and drops a coincident start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept_s ? (special_s ? DONE : CALC) : IDLE;
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX:        state_d = kill ? IDLE : DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the next state so they can be registered.
  always_comb begin
    ready_d = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
      end
      CALC, FIX: begin
        ready_d = 1'b0;
        busy_d  = 1'b1;
      end
      DONE: begin
        done_d  = 1'b1;
      end
      default: begin
        ready_d = 1'b1;
      end
    endcase
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
